mul_scheduler: RTL and testbench

- Shares one iterative signed multiplier engine between two requesters, e.g. two execute lanes or an execute lane plus a debug/DMA unit.
- Runs round-robin arbitration and a valid/ready request handshake per requester.
- Sequences the engine (load pulse, enable, done detection) with a watchdog timeout.
- Returns the 64-bit product on one shared response channel tagged with the requester id.

---
 rtl/mul_scheduler.sv | 89 ++++++++
 tb/tb_mul_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mul_scheduler.sv
// mul_scheduler: round-robin sharing of one iterative multiplier between two requesters
module mul_scheduler #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_p,
  output logic               resp_err,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_load,
  output logic               mul_ena,
  input  logic [2*WIDTH-1:0] mul_p,
  input  logic               mul_dne,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, grant, any_valid, done, tmo;
  logic [CNT_W-1:0] counter;
  // arbitration, engine strobes and completion detection
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = (state == IDLE) && any_valid && !grant;
    req1_ready = (state == IDLE) && any_valid && grant;
    mul_load   = state == LOAD;
    mul_ena    = state == RUN;
    resp_valid = state == RESP;
    busy       = state != IDLE;
    done       = mul_dne && (counter != '0);
    tmo        = counter == CNT_W'(TIMEOUT - 1);
  end
  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = any_valid ? LOAD : IDLE;
      LOAD:    state_nx = RUN;
      RUN:     state_nx = (done || tmo) ? RESP : RUN;
      RESP:    state_nx = resp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // operand latch, watchdog, result capture and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      resp_id    <= 1'b0;
      resp_p     <= '0;
      resp_err   <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      counter    <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        mul_a   <= grant ? req1_a : req0_a;
        mul_b   <= grant ? req1_b : req0_b;
        resp_id <= grant;
      end
      if (state == LOAD) counter <= '0;
      if (state == RUN) counter <= counter + 1'b1;
      if (state == RUN && done) begin
        resp_p   <= mul_p;
        resp_err <= 1'b0;
      end else if (state == RUN && tmo) begin
        resp_p   <= '0;
        resp_err <= 1'b1;
      end
      if (state == RESP && resp_ready) last_grant <= resp_id;
    end
  end
endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: directed plus random checks of mul_scheduler against an arithmetic reference
module tb_mul_scheduler;
  localparam int TO = 12;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, resp_ready = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic resp_valid, req0_ready, req1_ready, resp_id, resp_err, mul_load, mul_ena, mul_dne, busy;
  logic [63:0] resp_p, mul_p;
  logic [31:0] mul_a, mul_b;
  int n_cmp = 0, n_bad = 0;
  int lat_cfg = 1000, ecnt = 0;
  bit stale = 0, last_m = 1;

  mul_scheduler #(.WIDTH(32), .TIMEOUT(TO), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_p(resp_p),
    .resp_err(resp_err), .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load), .mul_ena(mul_ena),
    .mul_p(mul_p), .mul_dne(mul_dne), .busy(busy));

  always #5 clk = ~clk;

  // engine model: done after lat_cfg enabled steps, optional stale done on the first step
  always @(posedge clk)
    if (mul_load) ecnt <= 0;
    else if (mul_ena) ecnt <= ecnt + 1;
  assign mul_dne = mul_ena && ((ecnt >= lat_cfg) || (stale && ecnt == 0));
  assign mul_p = (ecnt >= lat_cfg) ? longint'(int'(mul_a)) * longint'(int'(mul_b)) : 64'hDEAD_BEEF_0BAD_F00D;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic job(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] b0,
                     input logic [31:0] a1, input logic [31:0] b1, input int lat, input int stall,
                     input bit stale_i, input bit keep);
    bit g, eerr, bad_rdy;
    logic [31:0] ea, eb;
    longint ep, p0;
    int loads, runs, cyc;
    logic id0;
    g = (v0 && v1) ? !last_m : v1;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    eerr = lat > TO - 1;
    ep = eerr ? 64'sd0 : longint'(int'(ea)) * longint'(int'(eb));
    lat_cfg = lat;
    stale = stale_i;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    chk("ready0", req0_ready, !g);
    chk("ready1", req1_ready, g);
    @(negedge clk);
    if (!keep) begin req0_valid = 0; req1_valid = 0; end
    chk("mul_a", mul_a, ea);
    chk("mul_b", mul_b, eb);
    loads = 0; runs = 0; cyc = 0; bad_rdy = 0;
    while (!resp_valid && cyc < 200) begin
      loads += mul_load;
      runs += mul_ena;
      bad_rdy |= req0_ready | req1_ready;
      @(negedge clk);
      cyc++;
    end
    chk("resp_arrived", resp_valid, 1);
    chk("load_pulses", loads, 1);
    chk("run_cycles", runs, eerr ? TO : lat + 1);
    chk("resp_id", resp_id, g);
    chk("resp_p", resp_p, ep);
    chk("resp_err", resp_err, eerr);
    p0 = resp_p;
    id0 = resp_id;
    repeat (stall) begin
      @(negedge clk);
      bad_rdy |= req0_ready | req1_ready;
      chk("hold_valid", resp_valid, 1);
      chk("hold_p", resp_p, p0);
      chk("hold_id", resp_id, id0);
    end
    chk("busy_ready", bad_rdy, 0);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("resp_done", resp_valid, 0);
    chk("idle", busy, 0);
    last_m = g;
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_load", mul_load, 0);
    chk("rst_ena", mul_ena, 0);
    chk("rst_p", resp_p, 0);
    chk("rst_a", mul_a, 0);
    // both requesters continuously valid: grants alternate starting with req0
    for (int i = 0; i < 4; i++)
      job(1, 1, 32'd10 + i, 32'd2, 32'd20 + i, 32'hFFFF_FFFD, 3 + i, 0, 0, i != 3);
    // basic signed product
    job(1, 0, 32'd3, 32'hFFFF_FFFC, 0, 0, 10, 0, 0, 0);
    // consumer stalls five cycles
    job(0, 1, 0, 0, 32'h1234_5678, 32'd1000, 4, 5, 0, 0);
    // engine never finishes, then a normal job
    job(1, 0, 32'd5, 32'd6, 0, 0, 1000, 0, 0, 0);
    job(1, 0, 32'd7, 32'd8, 0, 0, 5, 0, 0, 0);
    // stale done on the first run cycle is ignored
    job(0, 1, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 4, 0, 1, 0);
    // reset in the middle of RUN discards the job
    lat_cfg = 10; stale = 0;
    req0_valid = 1; req0_a = 32'd9; req0_b = 32'd9;
    @(negedge clk);
    req0_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid_run_ena", mul_ena, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ena", mul_ena, 0);
    seen = 0;
    repeat (15) begin
      seen |= resp_valid | busy;
      @(negedge clk);
    end
    chk("post_rst_quiet", seen, 0);
    last_m = 1;
    job(0, 1, 0, 0, 32'd11, 32'd13, 3, 0, 0, 0);
    job(1, 1, 32'd2, 32'd21, 32'd4, 32'd5, 2, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      int v;
      v = $urandom_range(1, 3);
      job(v[0], v[1], $urandom, $urandom, $urandom, $urandom,
          $urandom_range(1, TO + 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
